// File: rtl/pc_ctrl_pkg.sv
// Shared opcode/state encodings and branch-condition helper for the
// fetch-stage PC and branch controller.
package pc_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_COM  = 4'b0001,
        OP_END  = 4'b0010,
        OP_CALL = 4'b1010,
        OP_RET  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_JEQ  = 4'b1101,
        OP_JLT  = 4'b1110,
        OP_JNE  = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int FLAG_EQ = 0;
    localparam int FLAG_LT = 1;

    // True when a jump-class opcode should redirect, given the registered flags.
    function automatic logic branch_cond(input opcode_e op, input logic [1:0] flags);
        case (op)
            OP_JMP:  return 1'b1;
            OP_JEQ:  return flags[FLAG_EQ];
            OP_JLT:  return flags[FLAG_LT];
            OP_JNE:  return !flags[FLAG_EQ];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Decode-side control bus of the PC/branch unit: decode drives the
// instruction controls, the unit returns PC, flags and status.
interface pc_branch_unit_if #(
    parameter int PC_W  = 32,
    parameter int IMM_W = 18
);
    logic             start;
    logic             stall;
    logic             flags_we;
    logic [1:0]       alu_flags_in;
    logic [3:0]       id;
    logic [IMM_W-1:0] imm;
    logic [PC_W-1:0]  pc;
    logic [1:0]       alu_flags_out;
    logic             com_flag;
    logic             end_flag;
    logic             flush;
    logic             ras_overflow;
    logic             ras_underflow;

    modport master (
        output start, stall, flags_we, alu_flags_in, id, imm,
        input  pc, alu_flags_out, com_flag, end_flag, flush, ras_overflow, ras_underflow
    );

    modport slave (
        input  start, stall, flags_we, alu_flags_in, id, imm,
        output pc, alu_flags_out, com_flag, end_flag, flush, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: saturating LIFO with push, pop and synchronous clear.
// The top entry is only meaningful while o_empty is low.
module pc_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_top_idx;

    assign w_top_idx = AW'(r_cnt - CW'(1));
    assign o_top     = r_mem[w_top_idx];
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_empty   = (r_cnt == '0);

    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values; a blocking = here would create ordering races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the occupancy count
    // alone defines validity, so clearing it is enough and keeps this a RAM.
    always_ff @(posedge clk) begin
        if (i_push && !o_full && !i_clear) begin
            r_mem[AW'(r_cnt)] <= i_data;
        end
    end
endmodule

// File: rtl/pc_branch_unit.sv
// Fetch-stage PC and branch controller: run/halt FSM, next-PC selection,
// ALU flag register, sticky COM flag and return-address stack errors.
module pc_branch_unit
    import pc_ctrl_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              IMM_W     = 18,
    parameter int              PC_STEP   = 4,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             reset,
    pc_branch_unit_if.slave  bus
);
    state_e           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [1:0]       r_flags;
    logic             r_com;
    logic             r_ovf;
    logic             r_unf;

    opcode_e          w_op;
    logic [IMM_W-1:0] w_imm;
    logic             w_active;
    logic             w_clear;
    logic             w_cond;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [PC_W-1:0]  w_seq;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_next_pc;
    logic [PC_W-1:0]  w_ras_top;
    logic             w_ras_full;
    logic             w_ras_empty;

    assign w_op     = opcode_e'(bus.id);
    assign w_imm    = bus.imm;
    assign w_active = (r_state == ST_RUN) && !bus.stall;
    assign w_clear  = bus.start && (r_state == ST_HALT);
    assign w_seq    = r_pc + PC_W'(PC_STEP);
    assign w_target = PC_W'(w_imm);
    assign w_cond   = branch_cond(w_op, r_flags);

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_flush   = 1'b0;
        w_next_pc = w_seq;
        if (w_active) begin
            case (w_op)
                OP_JMP, OP_JEQ, OP_JLT, OP_JNE: begin
                    if (w_cond) begin
                        w_flush   = 1'b1;
                        w_next_pc = w_target;
                    end
                end
                OP_CALL: begin
                    w_push    = !w_ras_full;
                    w_flush   = 1'b1;
                    w_next_pc = w_target;
                end
                OP_RET: begin
                    if (!w_ras_empty) begin
                        w_pop     = 1'b1;
                        w_flush   = 1'b1;
                        w_next_pc = w_ras_top;
                    end
                end
                default: ;
            endcase
        end
    end

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (w_seq),
        .o_top   (w_ras_top),
        .o_full  (w_ras_full),
        .o_empty (w_ras_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_flags <= '0;
            r_com   <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            // A flag write coinciding with a restart keeps the written value.
            if (bus.flags_we) begin
                r_flags <= bus.alu_flags_in;
            end else if (w_clear) begin
                r_flags <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_pc    <= RESET_PC;
                    end
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (w_op == OP_END) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                        if (w_op == OP_COM)                 r_com <= 1'b1;
                        if (w_op == OP_CALL && w_ras_full)  r_ovf <= 1'b1;
                        if (w_op == OP_RET  && w_ras_empty) r_unf <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_pc    <= RESET_PC;
                        r_com   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pc            = r_pc;
    assign bus.alu_flags_out = r_flags;
    assign bus.com_flag      = r_com;
    assign bus.end_flag      = (r_state == ST_HALT);
    assign bus.flush         = w_flush;
    assign bus.ras_overflow  = r_ovf;
    assign bus.ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed-vector bench for pc_branch_unit: the driver pushes hand-computed
// expectations, an independent monitor pops and compares them each cycle.
module tb_pc_branch_unit;
    import pc_ctrl_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  flags;
        logic        com;
        logic        endf;
        logic        flush;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic drv_valid;
    exp_t exp_q[$];

    logic [1:0] e_flags;
    logic       e_com;
    logic       e_end;
    logic       e_ovf;
    logic       e_unf;

    pc_branch_unit_if #(.PC_W(32), .IMM_W(18)) bus ();

    pc_branch_unit #(
        .PC_W      (32),
        .IMM_W     (18),
        .PC_STEP   (4),
        .RAS_DEPTH (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Present one instruction for one cycle and queue the expected outcome.
    task automatic step(input logic st, input logic sl, input logic fwe, input logic [1:0] fin,
                        input logic [3:0] op, input logic [17:0] im,
                        input logic ex_flush, input logic [31:0] ex_pc);
        exp_t e;
        @(posedge clk);
        #2;
        bus.start        = st;
        bus.stall        = sl;
        bus.flags_we     = fwe;
        bus.alu_flags_in = fin;
        bus.id           = op;
        bus.imm          = im;
        drv_valid        = 1'b1;
        e.pc    = ex_pc;
        e.flags = e_flags;
        e.com   = e_com;
        e.endf  = e_end;
        e.flush = ex_flush;
        e.ovf   = e_ovf;
        e.unf   = e_unf;
        exp_q.push_back(e);
    endtask

    task automatic idle_and_drain();
        @(posedge clk);
        #2;
        drv_valid        = 1'b0;
        bus.start        = 1'b0;
        bus.stall        = 1'b1;
        bus.flags_we     = 1'b0;
        bus.id           = OP_NOP;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    bus.pc,                   32'h0);
        check({tag, "_flags"}, 32'(bus.alu_flags_out),   32'h0);
        check({tag, "_com"},   32'(bus.com_flag),        32'h0);
        check({tag, "_end"},   32'(bus.end_flag),        32'h0);
        check({tag, "_flush"}, 32'(bus.flush),           32'h0);
        check({tag, "_ovf"},   32'(bus.ras_overflow),    32'h0);
        check({tag, "_unf"},   32'(bus.ras_underflow),   32'h0);
    endtask

    // Monitor: flush is sampled mid-cycle, registered state one delta past the edge.
    initial begin : monitor
        int   idx;
        logic f;
        exp_t e;
        idx = 0;
        forever begin
            @(negedge clk);
            if (drv_valid) begin
                f = bus.flush;
                @(posedge clk);
                #1;
                idx++;
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_queue", idx), 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("v%0d_pc", idx),    bus.pc,                 e.pc);
                    check($sformatf("v%0d_flags", idx), 32'(bus.alu_flags_out), 32'(e.flags));
                    check($sformatf("v%0d_com", idx),   32'(bus.com_flag),      32'(e.com));
                    check($sformatf("v%0d_end", idx),   32'(bus.end_flag),      32'(e.endf));
                    check($sformatf("v%0d_flush", idx), 32'(f),                 32'(e.flush));
                    check($sformatf("v%0d_ovf", idx),   32'(bus.ras_overflow),  32'(e.ovf));
                    check($sformatf("v%0d_unf", idx),   32'(bus.ras_underflow), 32'(e.unf));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : driver
        n_checks = 0;
        n_errors = 0;
        drv_valid = 1'b0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.flags_we = 1'b0;
        bus.alu_flags_in = 2'b00;
        bus.id = OP_NOP;
        bus.imm = '0;
        e_flags = 2'b00; e_com = 1'b0; e_end = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;

        #3;
        check_reset_state("por");
        #9 reset = 1'b1;

        // IDLE holds, start enters RUN at 0, then sequential fetch.
        step(0, 0, 0, 2'b00, OP_NOP, 18'h0, 0, 32'h0);
        step(1, 0, 0, 2'b00, OP_NOP, 18'h0, 0, 32'h0);
        step(0, 0, 0, 2'b00, OP_NOP, 18'h0, 0, 32'h4);
        step(0, 0, 0, 2'b00, OP_NOP, 18'h0, 0, 32'h8);
        step(0, 0, 0, 2'b00, OP_NOP, 18'h0, 0, 32'hC);

        // Conditional branches on the registered flags.
        e_flags = 2'b01;
        step(0, 0, 1, 2'b01, OP_NOP, 18'h0,   0, 32'h10);
        step(0, 0, 0, 2'b00, OP_JEQ, 18'h40,  1, 32'h40);
        step(0, 0, 0, 2'b00, OP_JLT, 18'h80,  0, 32'h44);
        e_flags = 2'b00;
        step(0, 0, 1, 2'b00, OP_NOP, 18'h0,   0, 32'h48);
        e_flags = 2'b01;
        step(0, 0, 1, 2'b01, OP_JEQ, 18'h300, 0, 32'h4C);
        step(0, 0, 0, 2'b00, OP_JNE, 18'h400, 0, 32'h50);
        e_flags = 2'b10;
        step(0, 0, 1, 2'b10, OP_NOP, 18'h0,   0, 32'h54);
        step(0, 0, 0, 2'b00, OP_JLT, 18'h80,  1, 32'h80);
        step(0, 0, 0, 2'b00, OP_JNE, 18'h90,  1, 32'h90);
        step(0, 0, 0, 2'b00, OP_JMP, 18'h10,  1, 32'h10);

        // COM, END, HALT hold, restart.
        e_com = 1'b1;
        step(0, 0, 0, 2'b00, OP_COM, 18'h0,  0, 32'h14);
        step(0, 0, 0, 2'b00, OP_NOP, 18'h0,  0, 32'h18);
        e_end = 1'b1;
        step(0, 0, 0, 2'b00, OP_END, 18'h0,  0, 32'h18);
        step(0, 0, 0, 2'b00, OP_JMP, 18'h40, 0, 32'h18);
        e_end = 1'b0; e_com = 1'b0; e_flags = 2'b00;
        step(1, 0, 0, 2'b00, OP_NOP, 18'h0,  0, 32'h0);

        // Nested CALL/RET.
        step(0, 0, 0, 2'b00, OP_JMP,  18'h10,  1, 32'h10);
        step(0, 0, 0, 2'b00, OP_CALL, 18'h100, 1, 32'h100);
        step(0, 0, 0, 2'b00, OP_CALL, 18'h200, 1, 32'h200);
        step(0, 0, 0, 2'b00, OP_RET,  18'h0,   1, 32'h104);
        step(0, 0, 0, 2'b00, OP_RET,  18'h0,   1, 32'h14);

        // Fill the 4-deep RAS, overflow on the fifth, unwind, underflow.
        step(0, 0, 0, 2'b00, OP_CALL, 18'h20, 1, 32'h20);
        step(0, 0, 0, 2'b00, OP_CALL, 18'h30, 1, 32'h30);
        step(0, 0, 0, 2'b00, OP_CALL, 18'h40, 1, 32'h40);
        step(0, 0, 0, 2'b00, OP_CALL, 18'h50, 1, 32'h50);
        e_ovf = 1'b1;
        step(0, 0, 0, 2'b00, OP_CALL, 18'h60, 1, 32'h60);
        step(0, 0, 0, 2'b00, OP_RET,  18'h0,  1, 32'h44);
        step(0, 0, 0, 2'b00, OP_RET,  18'h0,  1, 32'h34);
        step(0, 0, 0, 2'b00, OP_RET,  18'h0,  1, 32'h24);
        step(0, 0, 0, 2'b00, OP_RET,  18'h0,  1, 32'h18);
        e_unf = 1'b1;
        step(0, 0, 0, 2'b00, OP_RET,  18'h0,  0, 32'h1C);

        // Stall: held PC, flags still writable, jump taken exactly once.
        step(0, 1, 0, 2'b00, OP_JMP, 18'h80, 0, 32'h1C);
        step(0, 1, 0, 2'b00, OP_JMP, 18'h80, 0, 32'h1C);
        e_flags = 2'b11;
        step(0, 1, 1, 2'b11, OP_JMP, 18'h80, 0, 32'h1C);
        step(0, 0, 0, 2'b00, OP_JMP, 18'h80, 1, 32'h80);
        step(0, 0, 0, 2'b00, OP_NOP, 18'h0,  0, 32'h84);
        step(0, 1, 0, 2'b00, OP_CALL, 18'h200, 0, 32'h84);
        step(0, 0, 0, 2'b00, OP_RET,  18'h0,   0, 32'h88);

        // start in RUN ignored, JEQ on EQ=1, unknown opcode is sequential.
        step(1, 0, 0, 2'b00, OP_NOP,  18'h0,   0, 32'h8C);
        step(0, 0, 0, 2'b00, OP_JEQ,  18'h500, 1, 32'h500);
        step(0, 0, 0, 2'b00, 4'b0101, 18'h0,   0, 32'h504);
        step(0, 0, 0, 2'b00, OP_CALL, 18'h600, 1, 32'h600);
        idle_and_drain();

        // Asynchronous reset mid-RUN, away from any clock edge.
        reset = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        reset = 1'b1;
        e_flags = 2'b00; e_com = 1'b0; e_end = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
        step(0, 0, 0, 2'b00, OP_NOP, 18'h0, 0, 32'h0);
        step(1, 0, 0, 2'b00, OP_NOP, 18'h0, 0, 32'h0);
        e_unf = 1'b1;
        step(0, 0, 0, 2'b00, OP_RET, 18'h0, 0, 32'h4);
        idle_and_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
